// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RISC-V constants for the writeback slice.
//   XLEN, REG_ADDR_W      : datapath and register-address widths
//   F3_LB .. F3_LHU       : load funct3 encodings
//   ldEntry_t, LD_ENTRY_W : layout of one buffered load return (rd, funct3, byte offset, raw word)
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [2:0]            funct3;
      logic [1:0]            byteOff;
      logic [XLEN-1:0]       rdata;
   } ldEntry_t;

   localparam int LD_ENTRY_W = $bits(ldEntry_t);

endpackage

// File: rtl/wb_load_fifo.sv
// wb_load_fifo
// Synchronous FIFO holding raw load returns until the writeback port is free.
// Full/empty come from the registered occupancy count, so a full FIFO never
// accepts a push in the same cycle it pops.
//   clk, rst      : clock, asynchronous active-high reset
//   i_push        : write i_pushData (ignored when full)
//   i_pushData    : entry to enqueue
//   i_pop         : drop the head entry (ignored when empty)
//   o_headData    : current head entry
//   o_full        : count == DEPTH
//   o_empty       : count == 0
module wb_load_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 42
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_pushData,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_headData,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign w_doPush   = i_push && !o_full;
   assign w_doPop    = i_pop && !o_empty;
   assign o_headData = r_mem[r_rdPtr];

   // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
   // push and pop leaves the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
   end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit
// Merges single-cycle ALU results and buffered load returns into one registered
// register-file write stream (we, rd, wd). ALU has priority unless the load at the
// FIFO head has waited STARVE_MAX cycles, in which case the load is forced through
// and alu_ready drops for that cycle.
//   clk, rst                       : clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_result : ALU result handshake
//   ld_valid/ld_ready/ld_rd/ld_funct3/ld_byte_off/ld_rdata : load return handshake
//   we, rd, wd                     : registered register-file write port
// Optional feature macro WB_SCOREBOARD_EN adds ld_issue, ld_issue_rd and busy_mask,
// a per-register pending-load mask.
module writeback_unit
   import riscv_pkg::*;
#(
   parameter int LD_DEPTH   = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_result,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [REG_ADDR_W-1:0] ld_rd,
   input  logic [2:0]            ld_funct3,
   input  logic [1:0]            ld_byte_off,
   input  logic [XLEN-1:0]       ld_rdata,
`ifdef WB_SCOREBOARD_EN
   input  logic                  ld_issue,
   input  logic [REG_ADDR_W-1:0] ld_issue_rd,
   output logic [XLEN-1:0]       busy_mask,
`endif
   output logic                  we,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [XLEN-1:0]       wd
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   ldEntry_t              w_pushEntry;
   ldEntry_t              w_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_force;
   logic                  w_takeAlu;
   logic                  w_popLoad;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [XLEN-1:0]       w_ldData;
   logic                  w_nextWe;
   logic [REG_ADDR_W-1:0] w_nextRd;
   logic [XLEN-1:0]       w_nextWd;
   logic [SW-1:0]         r_starveCnt;
   logic                  r_we;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [XLEN-1:0]       r_wd;

   assign w_pushEntry = '{rd: ld_rd, funct3: ld_funct3, byteOff: ld_byte_off, rdata: ld_rdata};

   wb_load_fifo #(
      .DEPTH (LD_DEPTH),
      .WIDTH (LD_ENTRY_W)
   ) u_loadFifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (ld_valid && ld_ready),
      .i_pushData (w_pushEntry),
      .i_pop      (w_popLoad),
      .o_headData (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   assign ld_ready  = !w_full;
   assign w_force   = (r_starveCnt == SW'(STARVE_MAX)) && !w_empty;
   assign alu_ready = !w_force;
   assign w_takeAlu = alu_valid && !w_force;
   assign w_popLoad = w_force || (!alu_valid && !w_empty);

   // Load extension: the byte lane comes from the full offset, the halfword lane
   // only from off[1], so misaligned halfwords quietly round down. Unknown funct3
   // values fall back to a plain word.
   always_comb begin
      w_byte = w_head.rdata[{w_head.byteOff, 3'b000} +: 8];
      w_half = w_head.rdata[{w_head.byteOff[1], 4'b0000} +: 16];
      case (w_head.funct3)
         F3_LB:   w_ldData = {{24{w_byte[7]}}, w_byte};
         F3_LH:   w_ldData = {{16{w_half[15]}}, w_half};
         F3_LBU:  w_ldData = {24'h0, w_byte};
         F3_LHU:  w_ldData = {16'h0, w_half};
         default: w_ldData = w_head.rdata;
      endcase
   end

   // Next write-port value. A retire to x0 still consumes the entry but leaves
   // the port idle with rd and wd at zero.
   always_comb begin
      w_nextWe = 1'b0;
      w_nextRd = '0;
      w_nextWd = '0;
      if (w_takeAlu) begin
         if (alu_rd != '0) begin
            w_nextWe = 1'b1;
            w_nextRd = alu_rd;
            w_nextWd = alu_result;
         end
      end else if (w_popLoad) begin
         if (w_head.rd != '0) begin
            w_nextWe = 1'b1;
            w_nextRd = w_head.rd;
            w_nextWd = w_ldData;
         end
      end
   end

   // Output register plus the starvation counter, which measures how long the
   // current head has been passed over and saturates at the forcing threshold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we        <= 1'b0;
         r_rd        <= '0;
         r_wd        <= '0;
         r_starveCnt <= '0;
      end else begin
         r_we <= w_nextWe;
         r_rd <= w_nextRd;
         r_wd <= w_nextWd;
         if (w_empty || w_popLoad)
            r_starveCnt <= '0;
         else if (r_starveCnt != SW'(STARVE_MAX))
            r_starveCnt <= r_starveCnt + 1'b1;
      end
   end

   assign we = r_we;
   assign rd = r_rd;
   assign wd = r_wd;

`ifdef WB_SCOREBOARD_EN
   logic [XLEN-1:0] r_busyMask;
   logic [XLEN-1:0] w_setMask;
   logic [XLEN-1:0] w_clrMask;

   // The clear is taken from the pop decision so the bit falls on the same edge
   // that raises we for that load; OR-ing the set last lets a new issue win.
   always_comb begin
      w_setMask = '0;
      w_clrMask = '0;
      if (ld_issue && (ld_issue_rd != '0)) w_setMask[ld_issue_rd] = 1'b1;
      if (w_popLoad && (w_head.rd != '0))  w_clrMask[w_head.rd]   = 1'b1;
   end

   // Pending-load mask; x0 can never be set, so bit 0 stays clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_busyMask <= '0;
      else     r_busyMask <= (r_busyMask & ~w_clrMask) | w_setMask;
   end

   assign busy_mask = r_busyMask;
`endif

endmodule
